sar_comp_emulator: RTL

- Digital stand-in for the analog comparator and capacitive DAC in front of the SAR logic.
- The SAR logic drives trial codes; this block answers with one comparator decision per clock, computed against a programmed "analog" target code.
- After end-of-conversion it checks the SAR's result against the held target and keeps pass/fail counts.
- Sits beside the SAR logic instances in the test wrapper and enables closed-loop on-chip self-test without the analog front end.

---
 rtl/sar_test_pkg.sv | 33 +++
 rtl/sar_comp_emulator_sat_counter.sv | 27 ++
 rtl/sar_comp_emulator.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sar_test_pkg.sv
// ---------------------------------------------------------------------------
// sar_test_pkg
// Shared definitions for the SAR self-test logic: the emulator state
// encoding, the default converter resolution and a clamp helper. The helper
// is used both to limit the offset-adjusted target to the legal code range
// and for any saturating arithmetic.
// ---------------------------------------------------------------------------
package sar_test_pkg;

  // Default converter resolution in bits
  localparam int NBITS_DEFAULT = 10;

  // Emulator phases: idle, tracking the input, bit-by-bit conversion,
  // waiting for the SAR to report its result
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    TRACK    = 2'd1,
    CONV     = 2'd2,
    WAIT_EOC = 2'd3
  } state_t;

  // Clamp a signed value into the range [0, max_val]
  function automatic int clamp_range(input int value, input int max_val);
    if (value < 0) begin
      return 0;
    end else if (value > max_val) begin
      return max_val;
    end else begin
      return value;
    end
  endfunction

endpackage

// File: rtl/sar_comp_emulator_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at its all-ones value instead of wrapping.
//   clk   : clock, all logic on the rising edge
//   rst   : asynchronous active-high reset, clears the count
//   inc   : count one event this cycle
//   count : current saturating count
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Increment on request unless the counter is already at full scale
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/sar_comp_emulator.sv
// ---------------------------------------------------------------------------
// sar_comp_emulator
// Digital stand-in for the comparator and capacitive DAC in front of the SAR
// logic. A programmed target code plays the role of the analog input. During
// a conversion the SAR presents one trial code per clock and this block
// answers with the comparator decision one cycle later. When the SAR signals
// end of conversion, its result is checked against the held target (plus the
// comparator offset, clamped to the code range) and pass/fail counts are
// kept.
//
// Ports:
//   wb_clk_i    : clock
//   wb_rst_i    : asynchronous active-high reset
//   target_i    : emulated analog input code
//   target_ld_i : load target_i into the target register
//   samp_i      : SAR sample phase (high = track, falling edge = convert)
//   dac_code_i  : SAR trial code for the current cycle
//   eoc_i       : SAR end of conversion
//   result_i    : SAR output code, valid with eoc_i
//   comp_o      : comparator decision
//   compn_o     : inverted comparator decision
//   busy_o      : conversion or result wait in progress
//   bit_idx_o   : decisions issued in the current conversion
//   done_o      : one-cycle pulse when a result has been checked
//   match_o     : outcome of the last check
//   timeout_o   : one-cycle pulse when the SAR never reported a result
//   pass_cnt_o  : saturating count of matching conversions
//   fail_cnt_o  : saturating count of mismatches and timeouts
// ---------------------------------------------------------------------------
module sar_comp_emulator
  import sar_test_pkg::*;
#(
  parameter int NBITS   = NBITS_DEFAULT,
  parameter int OFFSET  = 0,
  parameter int TIMEOUT = 4,
  parameter int CNT_W   = 8
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic [NBITS-1:0] target_i,
  input  logic             target_ld_i,
  input  logic             samp_i,
  input  logic [NBITS-1:0] dac_code_i,
  input  logic             eoc_i,
  input  logic [NBITS-1:0] result_i,
  output logic             comp_o,
  output logic             compn_o,
  output logic             busy_o,
  output logic [3:0]       bit_idx_o,
  output logic             done_o,
  output logic             match_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] pass_cnt_o,
  output logic [CNT_W-1:0] fail_cnt_o
);

  // Two extra bits give room for a sign and for target + offset overflow
  localparam int CMP_W = NBITS + 2;
  // The wait timer only has to count 0 .. TIMEOUT-1
  localparam int TMR_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [3:0]       LAST_IDX = 4'(NBITS - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam int               CODE_MAX = (1 << NBITS) - 1;

  state_t state, next_state;

  logic [NBITS-1:0] target_q;
  logic [NBITS-1:0] hold_q;
  logic             samp_q;
  logic             comp_q;
  logic [3:0]       bit_idx_q;
  logic [TMR_W-1:0] tmr_q;
  logic             done_q;
  logic             match_q;
  logic             timeout_q;

  logic signed [CMP_W-1:0] level;
  logic signed [CMP_W-1:0] trial;
  logic                    decision;
  logic [NBITS-1:0]        expected;
  logic                    result_ok;
  logic                    samp_rise;
  logic                    samp_fall;
  logic                    start_conv;
  logic                    early_eoc;
  logic                    abort;
  logic                    decide;
  logic                    conv_last;
  logic                    check;
  logic                    expire;
  logic                    hold_comp;
  logic                    pass_inc;
  logic                    fail_inc;

  // Comparator: offset-adjusted held target against the trial code, both
  // widened to a signed format so a negative level always loses
  assign level     = signed'(CMP_W'(hold_q)) + CMP_W'(OFFSET);
  assign trial     = signed'(CMP_W'(dac_code_i));
  assign decision  = (level >= trial);
  assign expected  = NBITS'(clamp_range(int'(level), CODE_MAX));
  assign result_ok = (result_i == expected);

  assign samp_rise = samp_i & ~samp_q;
  assign samp_fall = samp_q & ~samp_i;

  // Event decode. Inside CONV an early eoc takes priority over an abort, and
  // a normal decision happens only when neither occurs. In WAIT_EOC an eoc
  // arriving on the last allowed cycle beats the timeout.
  assign start_conv = (state == TRACK) && samp_fall;
  assign early_eoc  = (state == CONV) && eoc_i;
  assign abort      = (state == CONV) && !eoc_i && samp_rise;
  assign decide     = (state == CONV) && !eoc_i && !samp_rise;
  assign conv_last  = decide && (bit_idx_q == LAST_IDX);
  assign check      = (state == WAIT_EOC) && eoc_i;
  assign expire     = (state == WAIT_EOC) && !eoc_i && (tmr_q == TMR_LAST);
  assign hold_comp  = (state == WAIT_EOC) && !eoc_i && !expire;
  assign pass_inc   = check && result_ok;
  assign fail_inc   = (check && !result_ok) || early_eoc || expire;

  // State register
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (samp_i) next_state = TRACK;
      end
      TRACK: begin
        if (samp_fall) next_state = CONV;
      end
      CONV: begin
        if (early_eoc) begin
          next_state = IDLE;
        end else if (abort) begin
          next_state = TRACK;
        end else if (conv_last) begin
          next_state = WAIT_EOC;
        end
      end
      WAIT_EOC: begin
        if (check) begin
          next_state = samp_i ? TRACK : IDLE;
        end else if (expire) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // State-derived outputs
  always_comb begin
    busy_o = (state == CONV) || (state == WAIT_EOC);
  end

  // Input capture: sample-phase history, target register, and the held
  // target that is frozen for the duration of a conversion
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      samp_q   <= 1'b0;
      target_q <= '0;
      hold_q   <= '0;
    end else begin
      samp_q <= samp_i;
      if (target_ld_i) target_q <= target_i;
      if (state == TRACK) hold_q <= target_q;
    end
  end

  // Conversion progress: the decision register, the decision counter and
  // the result wait timer. The last decision stays visible while waiting
  // for eoc and is cleared whenever the emulator leaves the conversion.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      comp_q    <= 1'b0;
      bit_idx_q <= '0;
      tmr_q     <= '0;
    end else begin
      if (decide) begin
        comp_q <= decision;
      end else if (!hold_comp) begin
        comp_q <= 1'b0;
      end

      if (start_conv) begin
        bit_idx_q <= '0;
      end else if (decide) begin
        bit_idx_q <= bit_idx_q + 4'd1;
      end

      if (conv_last) begin
        tmr_q <= '0;
      end else if (state == WAIT_EOC) begin
        tmr_q <= tmr_q + TMR_W'(1);
      end
    end
  end

  // Check results: one-cycle done/timeout pulses and a sticky match flag
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      done_q    <= 1'b0;
      match_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      done_q    <= check || early_eoc;
      timeout_q <= expire;
      if (check) begin
        match_q <= result_ok;
      end else if (early_eoc || expire) begin
        match_q <= 1'b0;
      end
    end
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_pass_cnt (
    .clk  (wb_clk_i),
    .rst  (wb_rst_i),
    .inc  (pass_inc),
    .count(pass_cnt_o)
  );

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_fail_cnt (
    .clk  (wb_clk_i),
    .rst  (wb_rst_i),
    .inc  (fail_inc),
    .count(fail_cnt_o)
  );

  assign comp_o    = comp_q;
  assign compn_o   = ~comp_q;
  assign bit_idx_o = bit_idx_q;
  assign done_o    = done_q;
  assign match_o   = match_q;
  assign timeout_o = timeout_q;

endmodule
